// File: rtl/aq_axi_sdma64_desc_seq.sv
// rtl/aq_axi_sdma64_desc_seq.sv - in-order descriptor queue issuing to write/read DMA engines
// Optional watchdog enabled by defining AQ_SDMA_SEQ_TIMEOUT_EN.
module aq_axi_sdma64_desc_seq #(
    parameter int DEPTH_LOG2  = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  AQ_LOCAL_CLK,
    input  logic                  RST_N,
    input  logic                  PUSH_VALID,
    output logic                  PUSH_READY,
    input  logic                  PUSH_DIR,
    input  logic [31:0]           PUSH_ADRS,
    input  logic [31:0]           PUSH_COUNT,
    input  logic                  ENABLE,
    input  logic                  FLUSH,
    output logic                  WR_START,
    output logic [31:0]           WR_ADRS,
    output logic [31:0]           WR_COUNT,
    input  logic                  WR_READY,
    input  logic                  WR_INT,
    output logic                  RD_START,
    output logic [31:0]           RD_ADRS,
    output logic [31:0]           RD_COUNT,
    input  logic                  RD_READY,
    input  logic                  RD_INT,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [15:0]           DONE_CNT,
    output logic                  TIMEOUT
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LP_FULL    = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LP_LVL_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] LP_PTR_ONE = DEPTH_LOG2'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_ACCEPT = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    logic [1:0]            r_state;
    logic [DEPTH_LOG2-1:0] r_head;
    logic [DEPTH_LOG2-1:0] r_tail;
    logic [DEPTH_LOG2:0]   r_level;
    logic [31:0]           r_adrs_mem  [DEPTH];
    logic [31:0]           r_count_mem [DEPTH];
    logic                  r_dir_mem   [DEPTH];
    logic                  r_wr_start;
    logic                  r_rd_start;
    logic                  r_done;
    logic [15:0]           r_done_cnt;

    logic w_full;
    logic w_push;
    logic w_head_dir;
    logic w_sel_ready;
    logic w_sel_int;
    logic w_inflight;
    logic w_complete;
    logic w_wdog_hit;
    logic w_pop;

    assign w_full      = (r_level == LP_FULL);
    assign w_push      = PUSH_VALID & ~w_full & ~FLUSH;
    assign w_head_dir  = r_dir_mem[r_head];
    assign w_sel_ready = w_head_dir ? RD_READY : WR_READY;
    assign w_sel_int   = w_head_dir ? RD_INT : WR_INT;
    assign w_inflight  = (r_state == S_ACCEPT) || (r_state == S_RUN);
    assign w_complete  = w_inflight & w_sel_int;
    assign w_pop       = w_complete | w_wdog_hit;

`ifdef AQ_SDMA_SEQ_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        r_timeout;

    // INT wins over a watchdog expiry landing in the same cycle
    assign w_wdog_hit = w_inflight & ~w_sel_int & (r_wdog == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge AQ_LOCAL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wdog    <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == S_ISSUE) && !FLUSH && w_sel_ready)
                r_wdog <= 32'd0;
            else if (w_inflight)
                r_wdog <= r_wdog + 32'd1;
            if (w_wdog_hit)
                r_timeout <= 1'b1;
        end
    end

    assign TIMEOUT = r_timeout;
`else
    assign w_wdog_hit = 1'b0;
    assign TIMEOUT    = 1'b0;
`endif

    always_ff @(posedge AQ_LOCAL_CLK) begin
        if (w_push) begin
            r_adrs_mem[r_tail]  <= PUSH_ADRS;
            r_count_mem[r_tail] <= PUSH_COUNT;
            r_dir_mem[r_tail]   <= PUSH_DIR;
        end
    end

    // Flush while a descriptor is in flight keeps only the head entry
    always_ff @(posedge AQ_LOCAL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else if (FLUSH) begin
            if (w_inflight && w_pop) begin
                r_head  <= r_head + LP_PTR_ONE;
                r_tail  <= r_head + LP_PTR_ONE;
                r_level <= '0;
            end else if (w_inflight) begin
                r_tail  <= r_head + LP_PTR_ONE;
                r_level <= LP_LVL_ONE;
            end else begin
                r_tail  <= r_head;
                r_level <= '0;
            end
        end else begin
            if (w_push)
                r_tail <= r_tail + LP_PTR_ONE;
            if (w_pop)
                r_head <= r_head + LP_PTR_ONE;
            if (w_push && !w_pop)
                r_level <= r_level + LP_LVL_ONE;
            else if (!w_push && w_pop)
                r_level <= r_level - LP_LVL_ONE;
        end
    end

    always_ff @(posedge AQ_LOCAL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_wr_start <= 1'b0;
            r_rd_start <= 1'b0;
            r_done     <= 1'b0;
            r_done_cnt <= 16'd0;
        end else begin
            r_wr_start <= 1'b0;
            r_rd_start <= 1'b0;
            r_done     <= w_complete;
            if (w_complete)
                r_done_cnt <= r_done_cnt + 16'd1;
            case (r_state)
                S_IDLE: begin
                    if ((r_level != '0) && ENABLE && !FLUSH)
                        r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (FLUSH) begin
                        r_state <= S_IDLE;
                    end else if (w_sel_ready) begin
                        r_wr_start <= ~w_head_dir;
                        r_rd_start <= w_head_dir;
                        r_state    <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (w_pop)
                        r_state <= S_IDLE;
                    else if (!w_sel_ready)
                        r_state <= S_RUN;
                end
                default: begin
                    if (w_pop)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign PUSH_READY = ~w_full;
    assign LEVEL      = r_level;
    assign BUSY       = (r_state != S_IDLE);
    assign DONE       = r_done;
    assign DONE_CNT   = r_done_cnt;
    assign WR_START   = r_wr_start;
    assign RD_START   = r_rd_start;
    assign WR_ADRS    = (BUSY && !w_head_dir) ? r_adrs_mem[r_head]  : 32'd0;
    assign WR_COUNT   = (BUSY && !w_head_dir) ? r_count_mem[r_head] : 32'd0;
    assign RD_ADRS    = (BUSY &&  w_head_dir) ? r_adrs_mem[r_head]  : 32'd0;
    assign RD_COUNT   = (BUSY &&  w_head_dir) ? r_count_mem[r_head] : 32'd0;

endmodule

// File: doc/aq_axi_sdma64_desc_seq.md
Name: aq_axi_sdma64_desc_seq

Overview:
Descriptor sequencer sitting between the local-bus register block and the write/read DMA engines. Software or an upstream block pushes {direction, address, count} descriptors into a small in-order queue. The sequencer issues them one at a time to the matching engine via the START/READY/INT handshake, so back-to-back transfers run without per-transfer CPU intervention. It reports queue level, busy, per-descriptor done pulses and a completion counter.

Parameters:
DEPTH_LOG2, 2, log2 of queue depth (default 4 entries)
TIMEOUT_CYC, 65535, watchdog limit in cycles (used only with the optional feature)

Ports:
AQ_LOCAL_CLK  in  1  single clock
RST_N  in  1  asynchronous active-low reset
PUSH_VALID  in  1  descriptor push request
PUSH_READY  out  1  queue can accept a push; equals queue not full
PUSH_DIR  in  1  0 = write DMA channel, 1 = read DMA channel
PUSH_ADRS  in  32  descriptor address
PUSH_COUNT  in  32  descriptor byte count
ENABLE  in  1  level; 0 stops issue of new descriptors
FLUSH  in  1  pulse; discards all queued, not-yet-issued descriptors
WR_START  out  1  one-cycle start to write engine
WR_ADRS  out  32  write address
WR_COUNT  out  32  write count
WR_READY  in  1  write engine idle
WR_INT  in  1  write engine completion pulse
RD_START / RD_ADRS / RD_COUNT  out  1/32/32  same for read engine
RD_READY / RD_INT  in  1/1  same for read engine
LEVEL  out  DEPTH_LOG2+1  entries held, including the in-flight head
BUSY  out  1  state != IDLE
DONE  out  1  one-cycle pulse per completed descriptor
DONE_CNT  out  16  completed-descriptor counter, wraps 0xFFFF->0
TIMEOUT  out  1  sticky watchdog flag (tied 0 without the optional feature)

Behaviour:
- Reset: all outputs 0; queue empty; state IDLE; PUSH_READY=1 after reset.
- Push accepted when PUSH_VALID & PUSH_READY; the entry is written at the tail on the clock edge.
- PUSH_READY is computed from the registered LEVEL only. When full, a pop in the same cycle does not admit a push.
- Push and pop in the same cycle at non-full level: LEVEL unchanged.
- Pointers are DEPTH_LOG2 bits and wrap naturally.
- *_ADRS/*_COUNT of the selected channel show the head entry while state != IDLE; otherwise 0. The unselected channel's outputs stay 0.
- FSM states: IDLE, ISSUE, ACCEPT, RUN.
  - IDLE -> ISSUE: LEVEL != 0 & ENABLE.
  - ISSUE: wait for the selected channel's READY=1. On the first cycle it is seen, assert that channel's START for exactly 1 cycle -> ACCEPT.
  - ACCEPT: wait for READY=0 -> RUN.
  - RUN: wait for the selected channel's INT -> pop head, DONE=1 for one cycle, DONE_CNT+1 -> IDLE.
  - An INT on the selected channel seen in ACCEPT (fast or zero-count transfer) completes the descriptor directly, same actions as in RUN.
- INT on the non-selected channel, or in IDLE/ISSUE, is ignored.
- Descriptors complete strictly in push order. Only one is in flight across both channels.
- ENABLE=0 blocks only IDLE->ISSUE. A descriptor already issued runs to completion.
- FLUSH:
  - In IDLE or ISSUE: empties the whole queue, tail:=head, LEVEL:=0. From ISSUE, returns to IDLE with no START issued.
  - In ACCEPT or RUN: keeps only the in-flight head, LEVEL:=1; completion proceeds normally.
  - A push in the same cycle as FLUSH is dropped.
- Reset mid-transfer: sequencer returns to reset state immediately. The engines are reset separately via MASTER_RST.

Optional Feature:
AQ_SDMA_SEQ_TIMEOUT_EN
- Defined: a 32-bit watchdog clears on entry to ACCEPT and counts each cycle in ACCEPT/RUN. On reaching TIMEOUT_CYC: set TIMEOUT (sticky, cleared only by reset), pop the head without DONE and without a DONE_CNT increment, go to IDLE.
- Undefined: no counter is present, TIMEOUT is tied to 0, and the FSM waits indefinitely for INT.

Test Plan:
- Push W{0x1000,0x40}, engine READY=1 → WR_START one cycle with WR_ADRS=0x1000, WR_COUNT=0x40; after READY low then INT → DONE pulse, DONE_CNT=1, LEVEL=0, BUSY=0.
- Push 4 alternating W/R with ENABLE=0 → LEVEL=4, PUSH_READY=0, 5th push ignored. Set ENABLE=1 → 4 STARTs in push order on the correct channels, DONE_CNT=4.
- RD_READY=0 while head is a read → no RD_START. Raise RD_READY 10 cycles later → RD_START on the following cycle, exactly one pulse.
- 3 queued, FLUSH during RUN of the head → LEVEL=1, head completes, DONE_CNT+1, then IDLE with no further STARTs.
- WR_INT during a read descriptor's RUN → ignored, state stays RUN until RD_INT.
- With AQ_SDMA_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100, INT withheld → TIMEOUT=1 exactly 100 cycles after entering ACCEPT, DONE_CNT unchanged, next descriptor issued.
